mega_ram_arbiter: RTL
=====================

// Module: mega_ram_arbiter
// PURPOSE
// - Sits directly upstream of mega_ram and owns its single port. Arbitrates between
//   the AVR core data bus and a secondary DMA master (loader/display copy).
// - Tracks mega_ram's 1-cycle registered read latency.
// - Routes read data back to the master that issued the read.
// - Converts mega_ram's halt (post-reset clear) into a CPU stall and a DMA hold-off.
// PARAMETERS
// - ADDR_BUS_WIDTH  12  RAM address width; matches mega_ram.
// - DATA_BUS_WIDTH  8   RAM data width.
// - DMA_MAX_WAIT    4   Starvation limit in cycles (>=1). Used only with MEGA_RAM_ARB_FAIR_EN.
// PORTS
// - clk          in   1     System clock; all state on posedge.
// - rst          in   1     Reset, asynchronous, active-low.
// - cpu_cs       in   1     CPU selects RAM.
// - cpu_we       in   1     CPU write strobe.
// - cpu_re       in   1     CPU read strobe.
// - cpu_a        in   ADDR  CPU address.
// - cpu_d_in     in   DATA  CPU write data.
// - cpu_d_out    out  DATA  CPU read data; valid in the cycle after the read grant, else 0.
// - cpu_stall    out  1     CPU access not taken this cycle; CPU holds request.
// - dma_req      in   1     DMA request; hold with dma_we/dma_a/dma_d_in stable until dma_ack.
// - dma_we       in   1     1 = write, 0 = read.
// - dma_a        in   ADDR  DMA address.
// - dma_d_in     in   DATA  DMA write data.
// - dma_ack      out  1     Combinational; DMA granted this cycle.
// - dma_rvalid   out  1     Registered; pulses the cycle after a DMA read grant.
// - dma_d_out    out  DATA  = ram_d_out when dma_rvalid, else 0.
// - ram_cs       out  1     To mega_ram cs.
// - ram_we       out  1     To mega_ram we.
// - ram_re       out  1     To mega_ram re.
// - ram_a        out  ADDR  To mega_ram a.
// - ram_d_in     out  DATA  To mega_ram d_in.
// - ram_d_out    in   DATA  From mega_ram d_out.
// - ram_halt     in   1     From mega_ram halt (clear in progress).
// BEHAVIOUR
// Requests
// - cpu_act = cpu_cs & (cpu_we | cpu_re).
// Grant (combinational, per cycle)
// - ram_halt=1 -> no grant.
// - Else if force=1 and dma_req -> DMA.
// - Else cpu_act -> CPU.
// - Else dma_req -> DMA.
// Grant outputs
// - cpu_stall = cpu_act & ~cpu_grant.
// - dma_ack = dma_grant.
// Granted master drives ram_a / ram_d_in / ram_we; no grant -> ram_a=0, ram_d_in=0, ram_we=0.
// Read tracking
// - Registers rdp_cpu / rdp_dma set on a read grant (CPU: cpu_re & ~cpu_we; DMA: ~dma_we) for one cycle.
// - Registers clear when no read is granted.
// - ram_re = granted read | rdp_cpu | rdp_dma. Keeps mega_ram's gated d_out valid in the data cycle,
//   even when a different master writes in that same cycle.
// - ram_cs = any grant | rdp_cpu | rdp_dma.
// - cpu_d_out = rdp_cpu ? ram_d_out : 0.
// - dma_rvalid = rdp_dma.
// Back-to-back
// - Read at N then any access at N+1 is legal.
// - Read data for N returns in N+1 while the N+1 address is presented.
// ram_halt
// - rdp_* clear on the next edge.
// - ram_cs=0, ram_re=0, ram_we=0.
// - CPU stalls; DMA waits.
// - Wait counter frozen.
// Reset (rst=0, async)
// - rdp_cpu=0, rdp_dma=0, wait_cnt=0, force=0.
// - Hence cpu_d_out=0 and dma_rvalid=0 immediately.
// - Combinational outputs follow the inputs.
// Fairness state (wait_cnt, width clog2(DMA_MAX_WAIT+1), saturating)
// - Increments when dma_req & ~dma_grant & ~ram_halt.
// - Clears on dma_grant or ~dma_req.
// - force = (wait_cnt == DMA_MAX_WAIT).
// CONFIGURATION
// - Macro MEGA_RAM_ARB_FAIR_EN defined: fairness counter and force priority active.
//   DMA is guaranteed a grant within DMA_MAX_WAIT+1 cycles of request while ram_halt=0.
// - Macro MEGA_RAM_ARB_FAIR_EN undefined: strict CPU priority; force tied 0; counter removed.
//   DMA starves while cpu_act stays high.
// TESTING
// 1. After ram_halt falls: CPU writes 0xA5 to 0x123, then reads 0x123.
//    -> cpu_stall=0 both cycles; cpu_d_out=0xA5 the cycle after the read.
// 2. CPU idle, DMA read 0x010 (holds 0x3C).
//    -> dma_ack=1 same cycle; dma_rvalid=1 and dma_d_out=0x3C next cycle.
// 3. CPU reads every cycle, dma_req held, FAIR_EN, DMA_MAX_WAIT=4.
//    -> dma_ack on the 5th request cycle, cpu_stall=1 that cycle only.
//    Without the macro: no dma_ack until cpu_act drops.
// 4. CPU read 0x020 at N, DMA write 0x55->0x030 at N+1.
//    -> ram_re=1 at N+1; cpu_d_out correct at N+1; 0x030 reads back 0x55.
// 5. rst pulsed (rising to clear RAM), then ram_halt=1 for 256 cycles with both masters requesting.
//    -> cpu_stall=1, dma_ack=0, ram_cs=0 throughout.
//    Afterwards both complete and read 0x00.
// 6. rst driven low in the cycle after a DMA read grant.
//    -> dma_rvalid drops without a clock edge; no stale cpu_d_out/dma_d_out after release.

Source files
------------

// File: rtl/mega_ram_arbiter.sv
// Single-port owner for mega_ram: arbitrates AVR data bus vs DMA, tracks 1-cycle read latency.
// Define MEGA_RAM_ARB_FAIR_EN to enable DMA starvation protection (forced grant after DMA_MAX_WAIT).
module mega_ram_arbiter #(
  parameter int unsigned ADDR_BUS_WIDTH = 12,
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned DMA_MAX_WAIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_cs,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
  output logic                      cpu_stall,
  input  logic                      dma_req,
  input  logic                      dma_we,
  input  logic [ADDR_BUS_WIDTH-1:0] dma_a,
  input  logic [DATA_BUS_WIDTH-1:0] dma_d_in,
  output logic                      dma_ack,
  output logic                      dma_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] dma_d_out,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_re,
  output logic [ADDR_BUS_WIDTH-1:0] ram_a,
  output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
  input  logic [DATA_BUS_WIDTH-1:0] ram_d_out,
  input  logic                      ram_halt
);

  if (DMA_MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mega_ram_arbiter: DMA_MAX_WAIT must be >= 1");
  end

  logic cpu_act;
  logic cpu_grant;
  logic dma_grant;
  logic force_c;
  logic rdp_cpu_q, rdp_cpu_d;
  logic rdp_dma_q, rdp_dma_d;

  // Priority: halt blocks everything, then starved DMA, then CPU, then DMA.
  always_comb begin
    cpu_act   = cpu_cs & (cpu_we | cpu_re);
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (!ram_halt) begin
      if (force_c && dma_req) begin
        dma_grant = 1'b1;
      end else if (cpu_act) begin
        cpu_grant = 1'b1;
      end else if (dma_req) begin
        dma_grant = 1'b1;
      end
    end
  end

  // Port mux and read-latency tracking; a pending read keeps re high in its data cycle.
  always_comb begin
    ram_a     = '0;
    ram_d_in  = '0;
    ram_we    = 1'b0;
    rdp_cpu_d = cpu_grant & cpu_re & ~cpu_we;
    rdp_dma_d = dma_grant & ~dma_we;
    if (cpu_grant) begin
      ram_a    = cpu_a;
      ram_d_in = cpu_d_in;
      ram_we   = cpu_we;
    end else if (dma_grant) begin
      ram_a    = dma_a;
      ram_d_in = dma_d_in;
      ram_we   = dma_we;
    end
    ram_re     = ~ram_halt & (rdp_cpu_d | rdp_dma_d | rdp_cpu_q | rdp_dma_q);
    ram_cs     = ~ram_halt & (cpu_grant | dma_grant | rdp_cpu_q | rdp_dma_q);
    cpu_stall  = cpu_act & ~cpu_grant;
    dma_ack    = dma_grant;
    cpu_d_out  = rdp_cpu_q ? ram_d_out : '0;
    dma_d_out  = rdp_dma_q ? ram_d_out : '0;
    dma_rvalid = rdp_dma_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdp_cpu_q <= 1'b0;
      rdp_dma_q <= 1'b0;
    end else begin
      rdp_cpu_q <= rdp_cpu_d;
      rdp_dma_q <= rdp_dma_d;
    end
  end

`ifdef MEGA_RAM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DMA_MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Saturating count of cycles the DMA has waited; frozen while the RAM is clearing.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_grant || !dma_req) begin
      wait_cnt_d = '0;
    end else if (!ram_halt && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  assign force_c = (wait_cnt_q == MAX_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_c = 1'b0;
`endif

endmodule
